// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Instruction-fetch program counter generator. Selects the next
//               fetch PC from redirects (mispredict fix, exception, exception
//               return, decode jump, return-address-stack pop), a branch
//               prediction, or sequential advance. An optional return-address
//               stack (RAS) is included when FETCH_PC_GEN_RAS_EN is defined.
// Ports       : clk_i, rst_i (async active-high)
//               bp_error_i / bp_fix_pc_i   - mispredict flush, corrected PC
//               exc_i                       - exception, jumps to EXC_PC
//               iret_i / iret_pc_i          - return from exception
//               jal_i / jal_pc_i            - decode jump and target
//               jal_link_i / link_pc_i      - jump is a call, address to push
//               ret_i                       - decode detected a return
//               bp_taken_i / bp_pred_pc_i   - predictor taken, target
//               pc_ready_i                  - icache accepts pc_o
//               pc_o, pc_valid_o            - fetch PC and its valid
//               next_pc_o                   - combinational next PC
//               ras_empty_o, ras_full_o     - RAS occupancy flags
// Config      : FETCH_PC_GEN_RAS_EN - build the return-address stack
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h1000,
    parameter logic [XLEN-1:0] EXC_PC    = 32'h2000,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            bp_error_i,
    input  logic [XLEN-1:0] bp_fix_pc_i,
    input  logic            exc_i,
    input  logic            iret_i,
    input  logic [XLEN-1:0] iret_pc_i,
    input  logic            jal_i,
    input  logic [XLEN-1:0] jal_pc_i,
    input  logic            jal_link_i,
    input  logic [XLEN-1:0] link_pc_i,
    input  logic            ret_i,
    input  logic            bp_taken_i,
    input  logic [XLEN-1:0] bp_pred_pc_i,
    input  logic            pc_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic            w_ret_hit;    // ret_i with something to return to
    logic [XLEN-1:0] w_ras_top;
    logic            w_redirect;
    logic            w_hi_redirect; // sources that outrank jal/ret

    assign w_hi_redirect = bp_error_i | exc_i | iret_i;
    assign w_redirect    = w_hi_redirect | jal_i | w_ret_hit;

`ifdef FETCH_PC_GEN_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q;  // next slot to write; top is ptr-1
    logic [CNT_W-1:0] ras_cnt_q;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_push;
    logic             w_pop;

    assign w_ptr_dec   = ras_ptr_q - PTR_W'(1);
    assign w_ras_top   = ras_mem_q[w_ptr_dec];
    assign ras_empty_o = (ras_cnt_q == '0);
    assign ras_full_o  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
    assign w_ret_hit   = ret_i & ~ras_empty_o;
    assign w_push      = jal_i & jal_link_i & ~w_hi_redirect;
    assign w_pop       = w_ret_hit & ~w_hi_redirect & ~jal_i;

    // Storage needs no reset: a zero count makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            ras_mem_q[ras_ptr_q] <= link_pc_i;
        end
    end

    // Pushing while full overwrites the oldest entry because the write
    // pointer simply wraps onto it; the count saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (w_push) begin
            ras_ptr_q <= ras_ptr_q + PTR_W'(1);
            if (!ras_full_o) begin
                ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end
        end else if (w_pop) begin
            ras_ptr_q <= w_ptr_dec;
            ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end
    end
`else
    logic w_unused_ras;

    assign w_unused_ras = ^{ret_i, jal_link_i, link_pc_i};
    assign w_ret_hit    = 1'b0;
    assign w_ras_top    = '0;
    assign ras_empty_o  = 1'b1;
    assign ras_full_o   = 1'b0;
`endif

    // Next PC: redirects win regardless of the handshake; prediction and
    // sequential advance only happen once the current PC is accepted.
    always_comb begin
        pc_d = pc_q;
        if (bp_error_i) begin
            pc_d = bp_fix_pc_i;
        end else if (exc_i) begin
            pc_d = EXC_PC;
        end else if (iret_i) begin
            pc_d = iret_pc_i;
        end else if (jal_i) begin
            pc_d = jal_pc_i;
        end else if (w_ret_hit) begin
            pc_d = w_ras_top;
        end else if (pc_valid_o && pc_ready_i) begin
            pc_d = bp_taken_i ? bp_pred_pc_i : (pc_q + XLEN'(4));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = w_redirect ? ST_BUBBLE : ST_RUN;
            ST_RUN:    state_d = w_redirect ? ST_BUBBLE : ST_RUN;
            ST_BUBBLE: state_d = w_redirect ? ST_BUBBLE : ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q == ST_RUN);
    assign next_pc_o  = pc_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_gen
// Description : Self-checking bench for fetch_pc_gen. Directed scenarios plus
//               randomized traffic compared against a queue-based model.
//               Honours FETCH_PC_GEN_RAS_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h1000;
    localparam logic [31:0] EXC_PC    = 32'h2000;
    localparam int          RAS_DEPTH = 4;
`ifdef FETCH_PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bp_error_i, exc_i, iret_i, jal_i, jal_link_i, ret_i;
    logic        bp_taken_i, pc_ready_i;
    logic [31:0] bp_fix_pc_i, iret_pc_i, jal_pc_i, link_pc_i, bp_pred_pc_i;
    logic [31:0] pc_o, next_pc_o;
    logic        pc_valid_o, ras_empty_o, ras_full_o;

    int compared   = 0;
    int mismatched = 0;

    // Model state: current PC, whether it is presented as valid, stack contents.
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_ras[$];

    always #5 clk_i = ~clk_i;

    fetch_pc_gen #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bp_error_i(bp_error_i), .bp_fix_pc_i(bp_fix_pc_i),
        .exc_i(exc_i), .iret_i(iret_i), .iret_pc_i(iret_pc_i),
        .jal_i(jal_i), .jal_pc_i(jal_pc_i), .jal_link_i(jal_link_i),
        .link_pc_i(link_pc_i), .ret_i(ret_i),
        .bp_taken_i(bp_taken_i), .bp_pred_pc_i(bp_pred_pc_i),
        .pc_ready_i(pc_ready_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .next_pc_o(next_pc_o),
        .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bp_error_i = 0; exc_i = 0; iret_i = 0; jal_i = 0; jal_link_i = 0;
        ret_i = 0; bp_taken_i = 0; pc_ready_i = 1;
        bp_fix_pc_i = 0; iret_pc_i = 0; jal_pc_i = 0; link_pc_i = 0; bp_pred_pc_i = 0;
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_valid = 0;
        m_ras.delete();
    endtask

    // One clock: check the combinational next PC, clock, then check outputs.
    task automatic step(input string tag);
        logic [31:0] exp_next;
        bit hi, ret_hit, redir;
        #1;
        hi      = bp_error_i | exc_i | iret_i;
        ret_hit = RAS_EN && ret_i && (m_ras.size() > 0);
        redir   = hi | jal_i | ret_hit;
        if (bp_error_i)                exp_next = bp_fix_pc_i;
        else if (exc_i)                exp_next = EXC_PC;
        else if (iret_i)               exp_next = iret_pc_i;
        else if (jal_i)                exp_next = jal_pc_i;
        else if (ret_hit)              exp_next = m_ras[$];
        else if (m_valid && pc_ready_i) exp_next = bp_taken_i ? bp_pred_pc_i : m_pc + 32'd4;
        else                           exp_next = m_pc;
        check({tag, ":next_pc"}, next_pc_o, exp_next);

        if (!hi && jal_i && jal_link_i && RAS_EN) begin
            if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(link_pc_i);
        end else if (!hi && !jal_i && ret_hit) begin
            void'(m_ras.pop_back());
        end
        m_pc    = exp_next;
        m_valid = !redir;

        @(posedge clk_i);
        #1;
        check({tag, ":pc"},    pc_o,               m_pc);
        check({tag, ":valid"}, {31'd0, pc_valid_o}, {31'd0, m_valid});
        check({tag, ":empty"}, {31'd0, ras_empty_o},
              {31'd0, RAS_EN ? (m_ras.size() == 0) : 1'b1});
        check({tag, ":full"},  {31'd0, ras_full_o},
              {31'd0, RAS_EN ? (m_ras.size() == RAS_DEPTH) : 1'b0});
    endtask

    initial begin
        clr();
        rst_i = 1;
        model_reset();
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 0;

        // Boot cycle: reset PC shown but not valid, then sequential fetch.
        check("boot_pc",    pc_o, 32'h1000);
        check("boot_valid", {31'd0, pc_valid_o}, 32'd0);
        step("seq0"); check("seq0_pc", pc_o, 32'h1000); check("seq0_v", {31'd0, pc_valid_o}, 32'd1);
        step("seq1"); check("seq1_pc", pc_o, 32'h1004);
        step("seq2"); check("seq2_pc", pc_o, 32'h1008);

        // Stall with a taken prediction that must be ignored.
        pc_ready_i = 0; bp_taken_i = 1; bp_pred_pc_i = 32'hDEAD0000;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_pc",    pc_o, 32'h1008);
        check("stall_valid", {31'd0, pc_valid_o}, 32'd1);

        // Accepted taken prediction.
        pc_ready_i = 1; bp_pred_pc_i = 32'h0000_4440;
        step("pred"); check("pred_pc", pc_o, 32'h4440);
        clr();

        // Simultaneous redirects: mispredict fix wins.
        bp_error_i = 1; exc_i = 1; jal_i = 1; bp_fix_pc_i = 32'h3000; jal_pc_i = 32'h7000;
        step("prio"); check("prio_pc", pc_o, 32'h3000); check("prio_v", {31'd0, pc_valid_o}, 32'd0);
        clr();
        step("prio_run"); check("prio_run_v", {31'd0, pc_valid_o}, 32'd1);
        step("prio_adv"); check("prio_adv_pc", pc_o, 32'h3004);

        // Exception then wrap-around of the sequential adder.
        exc_i = 1; step("exc"); check("exc_pc", pc_o, 32'h2000);
        clr();
        iret_i = 1; iret_pc_i = 32'hFFFF_FFF8; step("iret");
        clr();
        step("wrap0"); step("wrap1"); check("wrap1_pc", pc_o, 32'hFFFF_FFFC);
        step("wrap2"); check("wrap2_pc", pc_o, 32'h0000_0000);

        // Calls fill the stack past its depth, then returns drain it.
        for (int i = 1; i <= 5; i++) begin
            clr();
            jal_i = 1; jal_link_i = 1; link_pc_i = 32'h100 * i; jal_pc_i = 32'h8000 + 32'h10 * i;
            step("call");
        end
        clr();
`ifdef FETCH_PC_GEN_RAS_EN
        check("ras_full", {31'd0, ras_full_o}, 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            ret_i = 1;
            step("ret");
`ifdef FETCH_PC_GEN_RAS_EN
            if (i < 4) check("ret_pc", pc_o, 32'h500 - 32'h100 * i);
`endif
        end
`ifdef FETCH_PC_GEN_RAS_EN
        check("ret_none_pc", pc_o, 32'h200);
        check("ret_empty",   {31'd0, ras_empty_o}, 32'd1);
`endif
        clr();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bp_error_i   = ($urandom_range(99) < 3);
            exc_i        = ($urandom_range(99) < 2);
            iret_i       = ($urandom_range(99) < 3);
            jal_i        = ($urandom_range(99) < 10);
            jal_link_i   = $urandom_range(1);
            ret_i        = ($urandom_range(99) < 10);
            bp_taken_i   = ($urandom_range(99) < 20);
            pc_ready_i   = ($urandom_range(99) < 70);
            bp_fix_pc_i  = $urandom & ~32'h3;
            iret_pc_i    = $urandom & ~32'h3;
            jal_pc_i     = $urandom & ~32'h3;
            link_pc_i    = $urandom & ~32'h3;
            bp_pred_pc_i = $urandom & ~32'h3;
            step("rand");
        end
        clr();

        // Asynchronous reset in the middle of a stall.
        pc_ready_i = 0;
        step("pre_rst0"); step("pre_rst1");
        #3 rst_i = 1;
        #1;
        check("rst_async_pc",    pc_o, 32'h1000);
        check("rst_async_valid", {31'd0, pc_valid_o}, 32'd0);
        check("rst_async_empty", {31'd0, ras_empty_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 0;
        model_reset();
        pc_ready_i = 1;
        step("post_rst0"); check("post_rst_pc", pc_o, 32'h1000); check("post_rst_v", {31'd0, pc_valid_o}, 32'd1);
        step("post_rst1"); check("post_rst1_pc", pc_o, 32'h1004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h1000, PC loaded by reset.
REQ-003 SHALL have parameter EXC_PC, default 32'h2000, exception handler PC.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports: bp_error_i in 1 mispredict flush; bp_fix_pc_i in XLEN corrected PC.
REQ-007 SHALL have ports: exc_i in 1 exception; iret_i in 1 return from exception; iret_pc_i in XLEN return PC.
REQ-008 SHALL have ports: jal_i in 1 decode jump; jal_pc_i in XLEN jump target; jal_link_i in 1 jump is a call; link_pc_i in XLEN return address to push.
REQ-009 SHALL have ports: ret_i in 1 decode detected return.
REQ-010 SHALL have ports: bp_taken_i in 1 predictor taken; bp_pred_pc_i in XLEN predicted target.
REQ-011 SHALL have ports: pc_ready_i in 1 icache accepts pc_o.
REQ-012 SHALL have ports: pc_o out XLEN fetch PC; pc_valid_o out 1 pc_o valid; next_pc_o out XLEN next PC register value (combinational); ras_empty_o out 1; ras_full_o out 1.

Function
REQ-013 SHALL select next PC by priority: bp_error_i -> bp_fix_pc_i; exc_i -> EXC_PC; iret_i -> iret_pc_i; jal_i -> jal_pc_i; ret_i with RAS non-empty -> RAS top; bp_taken_i -> bp_pred_pc_i; else pc_o+4.
REQ-014 SHALL apply redirects (first five sources) on the clock edge they are asserted, regardless of pc_ready_i.
REQ-015 SHALL apply prediction or sequential advance only when pc_valid_o & pc_ready_i; otherwise hold pc_o.
REQ-016 SHALL compute pc_o+4 modulo 2^XLEN (wrap from all-ones-minus-3 to 0).
REQ-017 SHALL implement FSM states BOOT, RUN, BUBBLE; pc_valid_o=1 only in RUN.
REQ-018 SHALL transition BOOT->RUN after one cycle; RUN->BUBBLE on any redirect; BUBBLE->RUN after one cycle; BUBBLE->BUBBLE on a further redirect in BUBBLE.
REQ-019 SHALL push link_pc_i onto RAS when jal_i & jal_link_i is the winning source.
REQ-020 SHALL pop RAS when ret_i is the winning source; ret_i with RAS empty SHALL have no redirect and no pop.
REQ-021 SHALL, when pushing while full, overwrite the oldest entry (circular pointer wrap), count saturating at RAS_DEPTH.
REQ-022 SHALL leave RAS unchanged on bp_error_i, exc_i and iret_i.
REQ-023 SHALL drive ras_empty_o=(count==0), ras_full_o=(count==RAS_DEPTH).

Reset
REQ-024 SHALL on rst_i asynchronously set pc_o=RESET_PC, pc_valid_o=0, state=BOOT, RAS count=0, pointer=0.
REQ-025 SHALL on rst_i mid-operation discard pending redirects and RAS contents; first valid PC after release is RESET_PC.

Configuration
REQ-026 SHALL compile RAS logic only when macro FETCH_PC_GEN_RAS_EN is defined.
REQ-027 SHALL, without FETCH_PC_GEN_RAS_EN, keep all ports, ignore ret_i, jal_link_i and link_pc_i, tie ras_empty_o=1, ras_full_o=0.

Verification
REQ-028 SHALL cover: release rst_i, pc_ready_i=1 -> cycle1 pc_valid_o=0 pc_o=0x1000; then 0x1000,0x1004,0x1008 valid.
REQ-029 SHALL cover: pc_ready_i=0 for 3 cycles at pc_o=0x1008 -> pc_o held 0x1008 valid=1; bp_taken_i ignored while stalled.
REQ-030 SHALL cover: bp_error_i=1, exc_i=1, jal_i=1 same cycle, bp_fix_pc_i=0x3000 -> pc_o=0x3000, valid=0 one cycle, then 0x3000 valid.
REQ-031 SHALL cover (RAS en): calls with link 0x100,0x200,0x300,0x400,0x500, depth 4 -> full=1; four returns redirect 0x500,0x400,0x300,0x200; fifth ret_i -> no redirect, empty=1.
REQ-032 SHALL cover: XLEN=32, pc_o=0xFFFFFFFC advancing -> pc_o=0x00000000; rst_i asserted mid-stall -> pc_o=0x1000 immediately, valid=0.
